// File: rtl/toy_scan_mem.sv
// toy_scan_mem: small CPU data/program memory with a bit-serial scan path.
// Scan mode shifts a new image in MSB-first while streaming the old contents out.
module toy_scan_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_en,
  input  logic          scan_in,
  output logic          scan_out,
  output logic          scan_wrap,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (DW > 2) ? $clog2(DW) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_sr;
  logic [CW-1:0] r_bit_cnt;
  logic [AW-1:0] r_ptr;
  logic          r_scan_out;
  logic          r_scan_wrap;

  logic [DW-1:0] w_cur_word;
  logic [DW-1:0] w_shift_src;
  logic [DW-1:0] w_sr_next;
  logic          w_slot_last;
  logic          w_ptr_last;

  // The first bit of a slot shifts out of the memory word itself, later bits out of sr.
  assign w_cur_word  = r_mem[r_ptr];
  assign w_shift_src = (r_bit_cnt == '0) ? w_cur_word : r_sr;
  assign w_sr_next   = {w_shift_src[DW-2:0], scan_in};
  assign w_slot_last = (r_bit_cnt == CW'(DW - 1));
  assign w_ptr_last  = (r_ptr == {AW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (scan_en) begin
      if (w_slot_last) begin
        r_mem[r_ptr] <= w_sr_next;
      end
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_ptr       <= '0;
      r_scan_out  <= 1'b0;
      r_scan_wrap <= 1'b0;
    end else if (scan_en) begin
      r_sr       <= w_sr_next;
      r_scan_out <= w_shift_src[DW-1];
      if (w_slot_last) begin
        r_bit_cnt   <= '0;
        r_ptr       <= r_ptr + AW'(1);
        r_scan_wrap <= w_ptr_last;
      end else begin
        r_bit_cnt   <= r_bit_cnt + CW'(1);
        r_scan_wrap <= 1'b0;
      end
    end else begin
      // Leaving scan mode drops any partial word; the next session restarts at word 0.
      r_bit_cnt   <= '0;
      r_ptr       <= '0;
      r_scan_wrap <= 1'b0;
    end
  end

  assign rdata     = r_mem[addr];
  assign scan_out  = r_scan_out;
  assign scan_wrap = r_scan_wrap;

endmodule

// File: tb/tb_toy_scan_mem.sv
// Self-checking bench for toy_scan_mem: directed steps plus random traffic,
// compared against a slot/bit-position model of the scan protocol.
module tb_toy_scan_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_out;
  logic       scan_wrap;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       we = 1'b0;
  logic [7:0] rdata;

  toy_scan_mem #(.AW(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .scan_wrap (scan_wrap),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory image, bits shifted in the current session,
  // the old word being streamed out and the word being assembled.
  logic [7:0] m_mem [16];
  int         m_bits = 0;
  logic [7:0] m_old = '0;
  logic [7:0] m_acc = '0;
  logic       m_so = 1'b0;
  logic       m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_i, input logic sen, input logic sin,
                      input logic we_i, input logic [3:0] a, input logic [7:0] wd);
    int w;
    int b;
    rst = rst_i; scan_en = sen; scan_in = sin; we = we_i; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    if (rst_i) begin
      for (int k = 0; k < 16; k++) m_mem[k] = '0;
      m_bits = 0; m_so = 1'b0; m_wrap = 1'b0;
    end else if (sen) begin
      w = (m_bits / 8) % 16;
      b = m_bits % 8;
      if (b == 0) begin
        m_old = m_mem[w];
        m_acc = '0;
      end
      m_so   = m_old[7 - b];
      m_acc  = {m_acc[6:0], sin};
      m_wrap = 1'b0;
      if (b == 7) begin
        m_mem[w] = m_acc;
        m_wrap   = (w == 15);
      end
      m_bits++;
    end else begin
      m_bits = 0;
      m_wrap = 1'b0;
      if (we_i) m_mem[a] = wd;
    end
    $display("step rst=%0b sen=%0b sin=%0b we=%0b addr=%0d wdata=%02h -> rdata=%02h so=%0b wrap=%0b",
             rst_i, sen, sin, we_i, a, wd, rdata, scan_out, scan_wrap);
    check("scan_out", 32'(scan_out), 32'(m_so));
    check("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
    check("rdata", 32'(rdata), 32'(m_mem[a]));
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    step(1'b0, 1'b0, 1'b0, 1'b0, a, 8'h00);
    check(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic sweep();
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'(k), 8'h00);
  endtask

  initial begin
    int wraps;
    int wrap_at;
    logic [7:0] word;
    logic [7:0] m2;
    logic       bit_v;
    for (int k = 0; k < 16; k++) m_mem[k] = '0;

    // Reset and empty memory
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("reset_scan_out", 32'(scan_out), 32'd0);
    check("reset_scan_wrap", 32'(scan_wrap), 32'd0);
    for (int k = 0; k < 16; k++) read_check("reset_mem", 4'(k), 8'h00);

    // CPU write/read
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'hA5);
    check("wr3_same_edge", 32'(rdata), 32'h A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h3C);
    check("wr15_same_edge", 32'(rdata), 32'h3C);
    read_check("mem3_kept", 4'd3, 8'hA5);

    // Random pre-load contents
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(k), 8'($urandom));

    // Full image A: word k = k
    wraps = 0; wrap_at = -1;
    for (int i = 0; i < 128; i++) begin
      word  = 8'(i / 8);
      bit_v = word[7 - (i % 8)];
      step(1'b0, 1'b1, bit_v, 1'b0, 4'($urandom), 8'h00);
      if (scan_wrap) begin wraps++; wrap_at = i; end
    end
    check("wrap_count_A", 32'(wraps), 32'd1);
    check("wrap_edge_A", 32'(wrap_at), 32'd127);

    // Image B (all ones) continues the session; scan_out must replay image A
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'($urandom), 8'h00);
      word = 8'(i / 8);
      check("readback_A", 32'(scan_out), 32'(word[7 - (i % 8)]));
    end
    for (int k = 0; k < 16; k++) read_check("image_B", 4'(k), 8'hFF);

    // Abort mid-word, then a full word 0x80 from address 0
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h11);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 4'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("abort_mem0", 32'(rdata), 32'h11);
    word = 8'h80;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, word[7 - i], 1'b0, 4'd0, 8'h00);
    read_check("after_abort_mem0", 4'd0, 8'h80);
    read_check("after_abort_mem1", 4'd1, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h11);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 4'd0, 8'h00);
    read_check("abort5_mem0", 4'd0, 8'h11);

    // Scan wins over a concurrent CPU write
    m2 = m_mem[2];
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 8'h77);
    read_check("prio_mem2", 4'd2, m2);
    read_check("prio_mem0", 4'd0, 8'h00);

    // Reset in the middle of a scan
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    check("midscan_rst_so", 32'(scan_out), 32'd0);
    for (int k = 0; k < 16; k++) read_check("midscan_rst_mem", 4'(k), 8'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) scan_en = ~scan_en;
      step(($urandom_range(0, 149) == 0), scan_en, 1'($urandom), 1'($urandom),
           4'($urandom), 8'($urandom));
    end
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/toy_scan_mem.md
Name: toy_scan_mem

Overview:
- 16x8 data/program memory that sits directly downstream of the 4-bit toy CPU core.
- Serves the CPU bus: addr, data_out→wdata, we, rdata→data_in.
- Also provides a serial scan-load path. While scan_en is high, a full memory image is shifted in bit-serially from a pin, and the previous contents are shifted out on scan_out at the same time.
- Used for program load and readback on the TinyTapeout pins.

Parameters:
- AW, 4, address width; depth = 2**AW words.
- DW, 8, word width in bits; must be >= 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- scan_en  in  1  1 = scan-load mode, 0 = CPU bus mode
- scan_in  in  1  serial load data, MSB of each word first
- scan_out  out  1  serial readback of the previous word contents, registered
- scan_wrap  out  1  one-cycle pulse when the last word (address 2**AW-1) is written by scan
- addr  in  AW  CPU address
- wdata  in  DW  CPU write data (from CPU data_out)
- we  in  1  CPU write enable
- rdata  out  DW  read data to CPU

Behaviour:
- State:
  - mem[0..2**AW-1] of DW bits
  - sr (DW-bit shift register)
  - bit_cnt (0..DW-1)
  - ptr (AW bits)
  - scan_out_q
  - scan_wrap_q
- Reset (rst=1 at an edge):
  - all mem words, sr, bit_cnt, ptr, scan_out_q and scan_wrap_q are cleared to 0.
  - Reset has priority over every other action.
- Reset outputs: scan_out=0, scan_wrap=0, rdata=0.
- rdata = mem[addr], combinational, valid in both modes.
- A write at edge N is visible on rdata immediately after edge N.
- CPU mode (scan_en=0):
  - we=1 → mem[addr] <= wdata at the edge.
  - bit_cnt <= 0, ptr <= 0, scan_wrap_q <= 0.
  - sr and scan_out_q hold.
- Scan mode (scan_en=1): we is ignored, so there are no CPU writes. Per edge:
  - bit_cnt==0:
    - sr <= {mem[ptr][DW-2:0], scan_in}
    - scan_out_q <= mem[ptr][DW-1]
  - bit_cnt!=0:
    - sr <= {sr[DW-2:0], scan_in}
    - scan_out_q <= sr[DW-1]
  - bit_cnt==DW-1, in addition:
    - mem[ptr] <= {sr[DW-2:0], scan_in}
    - ptr <= ptr+1, wrapping 2**AW-1→0
    - bit_cnt <= 0
  - otherwise: bit_cnt <= bit_cnt+1.
  - scan_wrap_q <= 1 only on the edge that writes address 2**AW-1; 0 otherwise.
- Resulting timing:
  - Each DW-cycle word slot replaces mem[ptr] with the DW bits received, MSB first.
  - scan_out emits the old mem[ptr], MSB first, delayed by one cycle: old MSB appears after the slot's first edge, old LSB after the last.
  - A full image is 2**AW*DW cycles (128 at defaults).
  - After wrap, a second image overwrites from address 0; scan_out then returns the first image.
- scan_en falling mid-word:
  - the partial word is discarded and mem[ptr] is unchanged;
  - bit_cnt and ptr are cleared on the next edge;
  - the next scan session starts at address 0, bit 0.
- scan_en toggles for one cycle (1→0→1): the session restarts at address 0.
- rst asserted mid-scan: everything clears; scan_en high on the following edge starts a new session at address 0.
- We and scan_en both high: scan wins and the CPU write is dropped.

Test Plan:
- Reset: drive rst=1 for 1 edge, then release → rdata=0x00 for addr 0..15, scan_out=0, scan_wrap=0.
- CPU write/read: write mem[3]=0xA5, then set addr=3 with we=0 → rdata=0xA5 right after the write edge. Then write mem[15]=0x3C with addr=15 → rdata=0x3C and mem[3] is still 0xA5.
- Full scan load: with scan_en=1, shift words 0x00..0x0F (value = addr), MSB first, over 128 edges. Check:
  - scan_wrap pulses exactly once, right after edge 128;
  - with scan_en=0, rdata at addr k = k for all k;
  - scan_out over those 128 cycles (one-cycle lag) equals the pre-load contents.
- Readback: after loading image A, shift a second image B of 128 bits (all 0xFF) → the scan_out stream equals image A bit-for-bit, and mem is all 0xFF afterwards.
- Abort mid-word: preload mem[0]=0x11, raise scan_en for 5 edges, drop it for 1 edge, then shift a full word 0x80 → mem[0]=0x80 and mem[1] is unchanged. A run that aborts after 5 bits leaves mem[0]=0x11.
- Priority: scan_en=1, we=1, addr=2, wdata=0x77 for 8 edges with scan_in=0 → mem[2] is unchanged and mem[0]=0x00. Then rst mid-scan → all state is 0.
